conv_line_sequencer: RTL
========================

Name: conv_line_sequencer

Overview:
- Frame-level controller for the 3x3 window filter datapath: ROM fetch, line-buffer FIFOs and window/matrix stage.
- Replaces per-stage position-compare enables with one FSM that does the following:
  - flushes the line-buffer FIFOs;
  - prefills two image rows;
  - streams one new ROM row per requested output line;
  - generates write/read/window-valid strobes with fixed, documented latencies.
- Sits between the LCD timing logic (frame/line pulses) and the ROM + line_buffer + matrix chain.

Parameters:
- PIC_WIDTH, 250, pixels per image row (>=3).
- PIC_HEIGHT, 250, image rows (>=3); output rows = PIC_HEIGHT-2.
- ADDR_W, 16, ROM address width; PIC_WIDTH*PIC_HEIGHT <= 2^ADDR_W.
- RST_CYCLES, 8, cycles fifo_rst_n is held low during flush (>=1).

Ports:
- lcd_pclk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_start  in  1  single-cycle pulse; starts (or restarts) a frame.
- line_start  in  1  single-cycle pulse; request one output row.
- fifo_rst_busy  in  1  line-buffer FIFO reset-busy.
- rom_addr  out  ADDR_W  ROM address; ROM read latency is 1 cycle.
- buf_wr_en  out  1  line-buffer write (valid_in); aligned to ROM data.
- buf_rd_en  out  1  line-buffer read-all (rd_en_all).
- win_valid  out  1  matrix stage valid_in; 1 cycle after buf_rd_en.
- fifo_rst_n  out  1  line-buffer FIFO reset, active-low.
- out_row  out  11  current output row index, 0..PIC_HEIGHT-3.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  single-cycle pulse at end of frame.
- err_overrun  out  1  sticky request-while-busy flag; cleared by frame_start.

Behaviour:
- Reset values (all outputs registered): rom_addr=0, buf_wr_en=0, buf_rd_en=0, win_valid=0, fifo_rst_n=1, out_row=0, busy=0, frame_done=0, err_overrun=0; state=IDLE.
- States: IDLE, FLUSH, WAIT_BUSY, PREFILL, LINE_WAIT, LINE, DONE.
- IDLE: frame_start -> FLUSH. line_start is ignored and does not set err_overrun.
- FLUSH:
  - fifo_rst_n=0 for exactly RST_CYCLES cycles.
  - Then -> WAIT_BUSY.
  - rom_addr is cleared to 0.
- WAIT_BUSY:
  - fifo_rst_n=1.
  - Advance to PREFILL on the first cycle fifo_rst_busy==0. No timeout.
- PREFILL:
  - Lasts 2*PIC_WIDTH cycles; rom_addr steps 0..2*PIC_WIDTH-1, +1 per cycle.
  - A fetch strobe is asserted each cycle; buf_wr_en = fetch strobe delayed 1 cycle.
  - buf_rd_en=0 throughout.
  - Then -> LINE_WAIT with rom_addr=2*PIC_WIDTH.
- LINE_WAIT: line_start -> LINE.
- LINE:
  - Lasts exactly PIC_WIDTH fetch cycles; rom_addr increments each cycle.
  - buf_wr_en and buf_rd_en both = fetch strobe delayed 1 (same cycles).
  - win_valid = buf_rd_en delayed 1.
  - out_row is constant during the line and increments by 1 when LINE exits.
  - After fetch of row PIC_HEIGHT-1 (out_row==PIC_HEIGHT-3 completing) -> DONE; else -> LINE_WAIT.
- DONE:
  - Waits until the delayed strobes have drained (2 cycles after the last fetch).
  - Pulses frame_done for 1 cycle, clears out_row and rom_addr to 0, then -> IDLE.
- Strobe pipeline: delayed buf_wr_en/buf_rd_en/win_valid always complete in order, even across a state change, except on abort or reset.
- err_overrun:
  - Set by line_start in FLUSH, WAIT_BUSY, PREFILL, LINE or DONE; the pulse is otherwise ignored (no queuing).
  - Cleared only by frame_start or reset.
- frame_start when not in IDLE (abort):
  - Next cycle the state is FLUSH.
  - All strobe pipeline registers are cleared (no stray buf_wr_en/win_valid).
  - out_row=0 and frame_done is not pulsed.
- Simultaneous frame_start and line_start: frame_start wins; err_overrun is cleared, not set.
- rst_n low mid-frame: all outputs go immediately (asynchronously) to their reset values.
- No arithmetic wrap: rom_addr peaks at PIC_WIDTH*PIC_HEIGHT-1.

Test Plan (PIC_WIDTH=8, PIC_HEIGHT=5, RST_CYCLES=4):
- Nominal frame: reset, frame_start, fifo_rst_busy low after 3 cycles, then line_start 3 times (spaced 20 cycles) -> fifo_rst_n low exactly 4 cycles; 16 buf_wr_en pulses carrying addrs 0..15; per line 8 buf_wr_en/buf_rd_en pulses (addr 16..23, 24..31, 32..39) with win_valid 1 cycle after each; out_row 0,1,2; frame_done pulse once, ~2 cycles after addr 39; busy low afterwards.
- Busy hold: keep fifo_rst_busy high 50 cycles after flush -> no rom_addr change and no buf_wr_en until busy falls; PREFILL starts the next cycle.
- Overrun: line_start during PREFILL and again mid-LINE -> err_overrun=1 and stays 1; line/address counts unchanged; next frame_start clears it.
- Abort: frame_start at 4th fetch of output row 1 -> strobes drop the next cycle; fifo_rst_n low 4 cycles; out_row=0; no frame_done; the fresh frame reproduces the nominal sequence.
- Async reset mid-LINE -> all outputs reset values without a clock edge; state IDLE; a line_start after release is ignored.
- Simultaneous frame_start+line_start in LINE_WAIT with err_overrun=1 -> FLUSH entered, err_overrun=0.

Source files
------------

// File: rtl/conv_line_sequencer.sv
// Purpose : frame-level sequencer for the 3x3 window filter (ROM fetch, line-buffer FIFOs, window stage).
// Latency : buf_wr_en/buf_rd_en follow the ROM fetch by 1 cycle, win_valid follows buf_rd_en by 1 cycle.
// Backpr. : none on the strobes; stalls only in WAIT_BUSY (fifo_rst_busy) and LINE_WAIT (line_start).
//
// Ports:
//   lcd_pclk, rst_n        clock, asynchronous active-low reset
//   frame_start            pulse: start a frame, or abort and restart one in progress
//   line_start             pulse: request one output row (valid only in LINE_WAIT)
//   fifo_rst_busy          line-buffer FIFO still busy after its reset
//   rom_addr               ROM address (ROM data arrives one cycle later)
//   buf_wr_en, buf_rd_en   line-buffer write / read-all strobes, aligned to ROM data
//   win_valid              window stage valid, one cycle after buf_rd_en
//   fifo_rst_n             line-buffer FIFO reset, active-low
//   out_row                current output row 0..PIC_HEIGHT-3
//   busy, frame_done       not-idle flag, end-of-frame pulse
//   err_overrun            sticky: line_start arrived when no row could be accepted
module conv_line_sequencer #(
    parameter int PIC_WIDTH  = 250,
    parameter int PIC_HEIGHT = 250,
    parameter int ADDR_W     = 16,
    parameter int RST_CYCLES = 8
) (
    input  logic              lcd_pclk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              fifo_rst_busy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              buf_wr_en,
    output logic              buf_rd_en,
    output logic              win_valid,
    output logic              fifo_rst_n,
    output logic [10:0]       out_row,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overrun
);

    localparam int CNT_W = $clog2(2 * PIC_WIDTH + RST_CYCLES);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(2 * PIC_WIDTH - 1);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(PIC_WIDTH - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(1);
    localparam logic [10:0]      LAST_ROW  = 11'(PIC_HEIGHT - 3);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        WAIT_BUSY,
        PREFILL,
        LINE_WAIT,
        LINE,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic fetch;
    logic fetch_line;
    logic last_row;
    logic req_err;

    always_comb begin
        fetch      = (state == PREFILL) || (state == LINE);
        fetch_line = (state == LINE);
        last_row   = (out_row == LAST_ROW);
        // line_start is only meaningful in LINE_WAIT; IDLE silently ignores it
        req_err    = line_start && (state != IDLE) && (state != LINE_WAIT);
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rom_addr    <= '0;
            buf_wr_en   <= 1'b0;
            buf_rd_en   <= 1'b0;
            win_valid   <= 1'b0;
            fifo_rst_n  <= 1'b1;
            out_row     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // frame_start beats a simultaneous line_start
            if (frame_start) begin
                err_overrun <= 1'b0;
            end else if (req_err) begin
                err_overrun <= 1'b1;
            end

            if (frame_start) begin
                // start or abort: flush the strobe pipeline so nothing stray reaches the buffers
                state      <= FLUSH;
                cnt        <= '0;
                fifo_rst_n <= 1'b0;
                rom_addr   <= '0;
                out_row    <= '0;
                busy       <= 1'b1;
                buf_wr_en  <= 1'b0;
                buf_rd_en  <= 1'b0;
                win_valid  <= 1'b0;
            end else begin
                // strobes trail the fetch and keep draining across state changes
                buf_wr_en <= fetch;
                buf_rd_en <= fetch_line;
                win_valid <= buf_rd_en;

                case (state)
                    IDLE: begin
                        cnt <= '0;
                    end
                    FLUSH: begin
                        if (cnt == RST_LAST) begin
                            fifo_rst_n <= 1'b1;
                            cnt        <= '0;
                            state      <= WAIT_BUSY;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_BUSY: begin
                        if (!fifo_rst_busy) begin
                            cnt   <= '0;
                            state <= PREFILL;
                        end
                    end
                    PREFILL: begin
                        rom_addr <= rom_addr + 1'b1;
                        if (cnt == PRE_LAST) begin
                            cnt   <= '0;
                            state <= LINE_WAIT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LINE_WAIT: begin
                        if (line_start) begin
                            cnt   <= '0;
                            state <= LINE;
                        end
                    end
                    LINE: begin
                        if (cnt == LINE_LAST) begin
                            cnt <= '0;
                            if (last_row) begin
                                // hold the final address so rom_addr never passes W*H-1
                                state <= DONE;
                            end else begin
                                rom_addr <= rom_addr + 1'b1;
                                out_row  <= out_row + 11'd1;
                                state    <= LINE_WAIT;
                            end
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            cnt      <= cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        // two cycles lets the last buf_wr_en/buf_rd_en/win_valid leave the pipe
                        if (cnt == DONE_LAST) begin
                            frame_done <= 1'b1;
                            out_row    <= '0;
                            rom_addr   <= '0;
                            busy       <= 1'b0;
                            cnt        <= '0;
                            state      <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
